// File: rtl/mux_arb_vc4.sv
// Four-class round-robin merge from per-class FIFOs into one stream with almost-full backpressure.
// Optional class-tag check on forwarded words: define MUX_TAG_CHECK_EN.
module mux_arb_vc4 #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned CLASS_LSB = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data0,
  input  logic [DATA_W-1:0] fifo_data1,
  input  logic [DATA_W-1:0] fifo_data2,
  input  logic [DATA_W-1:0] fifo_data3,
  input  logic              out_afull,
  output logic [3:0]        fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              idle_out,
  output logic [CNT_W-1:0]  word_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, PAUSE} state_t;

  if (CLASS_LSB + 2 > DATA_W) begin : g_bad_class_lsb
    $error("mux_arb_vc4: class field lies outside the data word");
  end

  state_t            state, state_d;
  logic [1:0]        rr_last, rr_d;
  logic [1:0]        pend_ch, pend_ch_d;
  logic              pend_valid, pend_valid_d;
  logic [3:0]        pop_d;
  logic              cap_valid;
  logic [1:0]        cap_ch;
  logic              idle_d;
  logic [3:0]        cand;
  logic [1:0]        grant;
  logic [1:0]        idx;
  logic              grant_ok;
  logic [DATA_W-1:0] sel;
  logic              tag_ok;

  // A FIFO being popped right now still reports its pre-pop level; mask it so a last word is never popped twice.
  always_comb begin
    cand     = ~fifo_empty & ~fifo_pop;
    grant    = rr_last;
    grant_ok = 1'b0;
    idx      = rr_last;
    for (int k = 1; k <= 4; k++) begin
      idx = rr_last + 2'(k);
      if (!grant_ok && cand[idx]) begin
        grant_ok = 1'b1;
        grant    = idx;
      end
    end
  end

  always_comb begin
    state_d      = state;
    rr_d         = rr_last;
    pend_ch_d    = pend_ch;
    pend_valid_d = 1'b0;
    pop_d        = 4'b0000;
    case (state)
      IDLE: begin
        if (enable && !out_afull && (fifo_empty != 4'b1111)) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!enable || (fifo_empty == 4'b1111)) begin
          state_d = IDLE;
        end else if (out_afull) begin
          state_d = PAUSE;
        end else if (grant_ok) begin
          pop_d        = 4'b0001 << grant;
          rr_d         = grant;
          pend_ch_d    = grant;
          pend_valid_d = 1'b1;
        end
      end
      PAUSE: begin
        if (!enable || (fifo_empty == 4'b1111)) state_d = IDLE;
        else if (!out_afull)                     state_d = ACTIVE;
      end
      default: state_d = IDLE;
    endcase
    // pend_valid moves into the capture stage next cycle, so it still counts as in flight.
    idle_d = (state_d == IDLE) && !pend_valid_d && !pend_valid;
  end

  always_comb begin
    case (cap_ch)
      2'd0:    sel = fifo_data0;
      2'd1:    sel = fifo_data1;
      2'd2:    sel = fifo_data2;
      default: sel = fifo_data3;
    endcase
  end

`ifdef MUX_TAG_CHECK_EN
  assign tag_ok = (sel[CLASS_LSB +: 2] == cap_ch);

  // Saturating count of words dropped for a class-tag mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (cap_valid && !tag_ok && (err_count != {CNT_W{1'b1}})) begin
      err_count <= err_count + CNT_W'(1);
    end
  end
`else
  assign tag_ok    = 1'b1;
  assign err_count = '0;
`endif

  // Pop at edge N, FIFO read data settles after N+1, word leaves on valid_out at N+2.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr_last    <= 2'd3;
      pend_ch    <= 2'd0;
      pend_valid <= 1'b0;
      fifo_pop   <= 4'b0000;
      cap_valid  <= 1'b0;
      cap_ch     <= 2'd0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      idle_out   <= 1'b1;
      word_count <= '0;
    end else begin
      state      <= state_d;
      rr_last    <= rr_d;
      pend_ch    <= pend_ch_d;
      pend_valid <= pend_valid_d;
      fifo_pop   <= pop_d;
      cap_valid  <= pend_valid;
      cap_ch     <= pend_ch;
      valid_out  <= cap_valid && tag_ok;
      idle_out   <= idle_d;
      if (cap_valid && tag_ok) begin
        data_out   <= sel;
        word_count <= word_count + CNT_W'(1);
      end
    end
  end

endmodule
